// File: rtl/spi_req_arbiter_if.sv
// Wishbone master-side bundle between spi_req_arbiter and the spi_master register port.
//   m_adr_o  : register address (0 data, 1 ss/div/mode, 2 ctrl, 3 status)
//   m_dat_o  : write data
//   m_dat_i  : read data
//   m_we_o   : write enable
//   m_stb_o  : strobe
//   m_cyc_o  : cycle
//   m_ack_i  : acknowledge
//   m_err_i  : bus error
// The master modport is the arbiter's view; the slave modport is the spi_master's view.
interface spi_req_arbiter_if #(
  parameter int unsigned WIDTH = 8
);
  logic [2:0]       m_adr_o;
  logic [WIDTH-1:0] m_dat_o;
  logic [WIDTH-1:0] m_dat_i;
  logic             m_we_o;
  logic             m_stb_o;
  logic             m_cyc_o;
  logic             m_ack_i;
  logic             m_err_i;

  modport master (
    output m_adr_o, m_dat_o, m_we_o, m_stb_o, m_cyc_o,
    input  m_dat_i, m_ack_i, m_err_i
  );

  modport slave (
    input  m_adr_o, m_dat_o, m_we_o, m_stb_o, m_cyc_o,
    output m_dat_i, m_ack_i, m_err_i
  );
endinterface

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master between NREQ requesters.
// For each granted request it programs ss/div/mode, writes the TX byte, sets go, polls
// status until RX data is present, clears go, reads the RX byte and returns it.
// Ports:
//   wb_clk_i, wb_rst_i : clock, asynchronous active-high reset
//   req_i, req_dat_i   : per-requester request level and packed TX bytes
//   cfg_mode_i/div_i/ctrl_i : shared transfer configuration (ctrl bit2 is driven here)
//   gnt_o, done_o, err_o, rsp_dat_o, busy_o : grant, completion pulse, abort pulse,
//                        received byte, busy flag
//   m                  : Wishbone master port to the spi_master
module spi_req_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned NREQ     = 3,
  parameter int unsigned POLL_MAX = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] req_dat_i,
  input  logic [1:0]            cfg_mode_i,
  input  logic [2:0]            cfg_div_i,
  input  logic [7:0]            cfg_ctrl_i,
  output logic [NREQ-1:0]       gnt_o,
  output logic [NREQ-1:0]       done_o,
  output logic                  err_o,
  output logic [WIDTH-1:0]      rsp_dat_o,
  output logic                  busy_o,
  spi_req_arbiter_if.master     m
);

  localparam int unsigned IdxW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned PollW = $clog2(POLL_MAX + 1);

  typedef enum logic [3:0] {
    StIdle, StWrSs, StWrData, StWrCtrl, StPoll,
    StWrClrOk, StWrClrTo, StRdData, StDone, StErr
  } state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [WIDTH-1:0]  tx_q, tx_d, rsp_q, rsp_d;
  logic [PollW-1:0]  poll_q, poll_d;
  logic              stb_q, stb_d, err_q, err_d;

  logic              arb_hit;
  logic [IdxW-1:0]   arb_idx, cand;
  logic              bus_ack, bus_err;
  logic [2:0]        ss_n;

  // Error wins over ack when both arrive together.
  assign bus_err = stb_q & m.m_err_i;
  assign bus_ack = stb_q & m.m_ack_i & ~m.m_err_i;
  assign ss_n    = ~3'(gnt_q);

  // First requester at or above ptr+1, wrapping.
  always_comb begin
    arb_hit = 1'b0;
    arb_idx = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % NREQ);
      if (!arb_hit && req_i[cand]) begin
        arb_hit = 1'b1;
        arb_idx = cand;
      end
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (arb_hit) state_d = StWrSs;
      StWrSs:    if (bus_err) state_d = StErr; else if (bus_ack) state_d = StWrData;
      StWrData:  if (bus_err) state_d = StErr; else if (bus_ack) state_d = StWrCtrl;
      StWrCtrl:  if (bus_err) state_d = StErr; else if (bus_ack) state_d = StPoll;
      StPoll: begin
        if (bus_err) state_d = StErr;
        else if (bus_ack) begin
          // Status bit0 is rempty: clear means the RX byte is ready.
          if (!m.m_dat_i[0])                          state_d = StWrClrOk;
          else if (poll_q == PollW'(POLL_MAX - 1))    state_d = StWrClrTo;
        end
      end
      StWrClrOk: if (bus_err) state_d = StErr; else if (bus_ack) state_d = StRdData;
      StWrClrTo: if (bus_err || bus_ack) state_d = StErr;
      StRdData:  if (bus_err) state_d = StErr; else if (bus_ack) state_d = StDone;
      StDone:    state_d = StIdle;
      StErr:     state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Registered outputs and datapath next values.
  always_comb begin
    gnt_d  = gnt_q;
    ptr_d  = ptr_q;
    tx_d   = tx_q;
    rsp_d  = rsp_q;
    poll_d = poll_q;
    done_d = '0;
    err_d  = 1'b0;
    stb_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (arb_hit) begin
          gnt_d = NREQ'(1) << arb_idx;
          ptr_d = arb_idx;
          tx_d  = req_dat_i[arb_idx*WIDTH +: WIDTH];
        end
      end
      StWrSs, StWrData, StWrCtrl, StPoll, StWrClrOk, StWrClrTo, StRdData: begin
        // Drop on the terminating edge; raising only from low forces the idle gap.
        stb_d = stb_q ? ~(m.m_ack_i | m.m_err_i) : 1'b1;
        if (state_q == StPoll && bus_ack && m.m_dat_i[0]) poll_d = poll_q + PollW'(1);
        if (state_q == StRdData && bus_ack) rsp_d = m.m_dat_i;
      end
      StDone: begin
        done_d = gnt_q;
        gnt_d  = '0;
        poll_d = '0;
      end
      StErr: begin
        err_d  = 1'b1;
        gnt_d  = '0;
        poll_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      gnt_q  <= '0;
      ptr_q  <= IdxW'(NREQ - 1);
      tx_q   <= '0;
      rsp_q  <= '0;
      poll_q <= '0;
      done_q <= '0;
      err_q  <= 1'b0;
      stb_q  <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      ptr_q  <= ptr_d;
      tx_q   <= tx_d;
      rsp_q  <= rsp_d;
      poll_q <= poll_d;
      done_q <= done_d;
      err_q  <= err_d;
      stb_q  <= stb_d;
    end
  end

  // Address/data/we decode from state; all zero outside bus states.
  always_comb begin
    m.m_adr_o = '0;
    m.m_dat_o = '0;
    m.m_we_o  = 1'b0;
    unique case (state_q)
      StWrSs: begin
        m.m_adr_o = 3'd1;
        m.m_dat_o = WIDTH'({cfg_mode_i, cfg_div_i, ss_n});
        m.m_we_o  = 1'b1;
      end
      StWrData: begin
        m.m_adr_o = 3'd0;
        m.m_dat_o = tx_q;
        m.m_we_o  = 1'b1;
      end
      StWrCtrl: begin
        m.m_adr_o = 3'd2;
        m.m_dat_o = WIDTH'(cfg_ctrl_i | 8'h04);
        m.m_we_o  = 1'b1;
      end
      StPoll:   m.m_adr_o = 3'd3;
      StWrClrOk, StWrClrTo: begin
        m.m_adr_o = 3'd2;
        m.m_dat_o = WIDTH'(cfg_ctrl_i & 8'hfb);
        m.m_we_o  = 1'b1;
      end
      StRdData: m.m_adr_o = 3'd0;
      default: ;
    endcase
  end

  assign m.m_stb_o  = stb_q;
  assign m.m_cyc_o  = stb_q;
  assign gnt_o      = gnt_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign rsp_dat_o  = rsp_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
Shares one spi_master between NREQ requesters. Arbitration is round-robin. The block drives the spi_master's Wishbone slave port as a bus master.
- For each granted request it programs slave select, divider and mode, writes the TX byte and sets go. It then polls status until RX data is present, clears go, reads the RX byte and returns it to the requester.
- Requester i always maps to slave select line i.

Parameters:
WIDTH, 8, data width of the Wishbone data bus and request payload
NREQ, 3, number of requesters (max 3, one per ss line)
POLL_MAX, 255, maximum number of status polls before timeout

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
req_i  in  NREQ  per-requester request level; held until matching done_o/err_o
req_dat_i  in  NREQ*WIDTH  packed TX bytes; requester i uses bits [i*WIDTH +: WIDTH]
cfg_mode_i  in  2  {cpol,cpha} for all transfers
cfg_div_i  in  3  SPI clock divider
cfg_ctrl_i  in  8  control byte template; bit2 (go) is overridden by this block
gnt_o  out  NREQ  one-hot grant, held for the whole transaction
done_o  out  NREQ  one-cycle pulse on the granted bit when rsp_dat_o is valid
err_o  out  1  one-cycle pulse, transaction aborted (bus error or poll timeout)
rsp_dat_o  out  WIDTH  received byte, valid with done_o and held until the next done
busy_o  out  1  high in every state except IDLE
m_adr_o  out  3  Wishbone address to spi_master
m_dat_o  out  WIDTH  Wishbone write data
m_dat_i  in  WIDTH  Wishbone read data
m_we_o  out  1  write enable
m_stb_o  out  1  strobe
m_cyc_o  out  1  cycle
m_ack_i  in  1  acknowledge
m_err_i  in  1  error

Behaviour:
- Reset (async): every output is 0. State is IDLE, the round-robin pointer is NREQ-1, the poll counter is 0.
- Arbitration (IDLE):
  - If any req_i bit is set, grant the first set bit searching upward from pointer+1, wrapping modulo NREQ.
  - Latch the granted TX byte, then assert gnt_o and move the pointer to the granted index, all in the same edge.
  - Next state is WR_SS.
  - A requester that drops req_i mid-transaction has no effect; the transaction completes normally.
- Bus access rule, applies to every Wishbone state:
  - Assert m_cyc_o and m_stb_o with the address, data and we for that state.
  - On m_ack_i, deassert stb/cyc on the next edge and advance.
  - stb/cyc stay low for at least one cycle between accesses.
  - m_err_i takes priority over m_ack_i and goes to ERR.
- States (address, data):
  - WR_SS: adr 1, write {cfg_mode_i, cfg_div_i, ss_n}, where ss_n = all-ones with bit[gnt] cleared.
  - WR_DATA: adr 0, write the latched TX byte.
  - WR_CTRL: adr 2, write cfg_ctrl_i with bit2 = 1.
  - POLL: adr 3, read.
    - On ack, if m_dat_i[0] == 0 (rempty clear), go to WR_CLR_OK.
    - Otherwise increment the poll counter.
    - If the counter reaches POLL_MAX, go to WR_CLR_TO; else re-issue POLL after the gap cycle.
  - WR_CLR_OK / WR_CLR_TO: adr 2, write cfg_ctrl_i with bit2 = 0. Then go to RD_DATA or ERR respectively.
  - RD_DATA: adr 0, read. On ack, capture m_dat_i into rsp_dat_o and go to DONE.
  - DONE: pulse done_o[gnt] for one cycle. Clear gnt_o and the poll counter, go to IDLE.
  - ERR: pulse err_o for one cycle. Clear gnt_o, the poll counter and stb/cyc, go to IDLE; no retry.
- Minimum latency, req_i to done_o, with single-cycle acks and the first poll successful: 1 grant cycle, then 6 accesses of 2 cycles each (ack + gap), then 1 cycle for DONE, giving 14 cycles.
- Simultaneous events:
  - New requests during a transaction wait.
  - The arbiter re-evaluates on the cycle after DONE/ERR (the IDLE cycle).
- Reset mid-transaction aborts immediately. stb/cyc drop asynchronously and no done/err pulse is generated.

Test Plan:
- Single request: req_i=3'b001, TX 8'hA5, poll succeeds first time, m_dat_i=8'h3C on RD_DATA.
  -> Writes are adr1 = {mode,div,3'b110}, adr0 = A5, adr2 go=1, adr2 go=0.
  -> done_o=3'b001 and rsp_dat_o=3C, 14 cycles after req.
- Round-robin: req_i=3'b111 held.
  -> Grants in order 001, 010, 100, 001.
  -> ss_n written is 110, 101, 011 respectively.
- Polling: status returns rempty=1 three times, then 0.
  -> Exactly 4 adr3 reads, each separated by ≥1 idle cycle, then WR_CLR and RD_DATA.
- Timeout: POLL_MAX=4, rempty stays 1.
  -> 4 polls, then a ctrl write with go=0, then an err_o pulse and no done_o.
  -> The next request is serviced normally.
- Bus error: m_err_i asserted during WR_DATA.
  -> err_o pulses, gnt_o clears, no further bus accesses for that transaction.
- Async reset asserted during POLL.
  -> All outputs are 0 within the same cycle, state is IDLE.
  -> After release with req_i=3'b010, the grant goes to 010 (pointer reset to NREQ-1).
